vz_image_loader: RTL and testbench

//  Parametrised .VZ image loader between the HPS ioctl download port and system RAM.

---
 rtl/vz_image_loader_if.sv | 59 +++++
 rtl/vz_image_loader.sv | 289 ++++++++++++++++++++++++++++
 tb/tb_vz_image_loader.sv | 350 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vz_image_loader_if.sv
// vz_image_loader_if
//   Groups the two byte streams handled by the .VZ image loader:
//   the HPS ioctl download stream coming in, and the RAM write handshake
//   going out.
//
//   Signals
//     ioctl_download  high for the whole file transfer
//     ioctl_wr        one-cycle byte strobe
//     ioctl_addr      byte offset within the file
//     ioctl_data      file byte
//     ioctl_wait      loader cannot take another byte; HPS holds strobes
//     vz_addr         RAM write address
//     vz_data         RAM write data
//     vz_wr           RAM write request, held until vz_ack
//     vz_ack          RAM accepted the write this cycle
//
//   Modports
//     slave   loader side (consumes ioctl, drives the RAM write port)
//     master  environment side (HPS + RAM)
interface vz_image_loader_if #(
  parameter int ADDR_W = 16
);

  logic              ioctl_download;
  logic              ioctl_wr;
  logic [ADDR_W-1:0] ioctl_addr;
  logic [7:0]        ioctl_data;
  logic              ioctl_wait;

  logic [ADDR_W-1:0] vz_addr;
  logic [7:0]        vz_data;
  logic              vz_wr;
  logic              vz_ack;

  modport slave (
    input  ioctl_download,
    input  ioctl_wr,
    input  ioctl_addr,
    input  ioctl_data,
    output ioctl_wait,
    output vz_addr,
    output vz_data,
    output vz_wr,
    input  vz_ack
  );

  modport master (
    output ioctl_download,
    output ioctl_wr,
    output ioctl_addr,
    output ioctl_data,
    input  ioctl_wait,
    input  vz_addr,
    input  vz_data,
    input  vz_wr,
    output vz_ack
  );

endinterface

// File: rtl/vz_image_loader.sv
// vz_image_loader
//   Loads a .VZ image streamed over the HPS ioctl port into system RAM.
//   The 24-byte header is checked ("VZ" magic, type F0/F1) and its start
//   address captured; body bytes are queued in a small FIFO and written to
//   RAM through a write/ack handshake. Once the body has drained, the BASIC
//   (F0) or machine-code (F1) pointer table is patched, and completion or
//   error is reported.
//
//   Ports
//     I_CLK      system clock
//     I_RST_N    asynchronous reset, active low
//     bus        vz_image_loader_if.slave: ioctl download stream in,
//                RAM write handshake out, ioctl_wait back-pressure
//     load_done  one-cycle pulse on successful completion
//     load_err   sticky error, cleared when the next download starts
//     exec_addr  start address from the header, valid with load_done
//     is_basic   1 = type F0 (BASIC), 0 = type F1 (machine code)
//
//   ADDR_W must match the interface instance and be at least 16, since
//   addresses are assembled from and patched as lo/hi byte pairs.
module vz_image_loader #(
  parameter int                ADDR_W     = 16,
  parameter int                FIFO_DEPTH = 4,
  parameter int                HDR_LEN    = 24,
  parameter logic [ADDR_W-1:0] BASIC_PTR  = ADDR_W'(16'h78A4),
  parameter logic [ADDR_W-1:0] BASIC_END  = ADDR_W'(16'h78F9),
  parameter logic [ADDR_W-1:0] MCODE_PTR  = ADDR_W'(16'h788E)
) (
  input  logic              I_CLK,
  input  logic              I_RST_N,
  vz_image_loader_if.slave  bus,
  output logic              load_done,
  output logic              load_err,
  output logic [ADDR_W-1:0] exec_addr,
  output logic              is_basic
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = ADDR_W + 8;

  localparam logic [CNT_W-1:0]  CNT_FULL   = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);
  localparam logic [ADDR_W-1:0] OFS_MAGIC0 = '0;
  localparam logic [ADDR_W-1:0] OFS_MAGIC1 = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] OFS_TYPE   = ADDR_W'(HDR_LEN - 3);
  localparam logic [ADDR_W-1:0] OFS_LO     = ADDR_W'(HDR_LEN - 2);
  localparam logic [ADDR_W-1:0] OFS_HI     = ADDR_W'(HDR_LEN - 1);
  localparam logic [ADDR_W-1:0] ONE_A      = ADDR_W'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HEADER,
    S_BODY,
    S_DRAIN,
    S_PATCH,
    S_DONE,
    S_ERROR
  } state_t;

  state_t            state;
  logic              dl_q;

  logic [ENT_W-1:0]  fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;

  logic [ADDR_W-1:0] cur_addr;
  logic [7:0]        start_lo;
  logic [7:0]        start_hi;
  logic              is_basic_q;
  logic              wrapped;
  logic [2:0]        patch_idx;

  logic              vz_wr_q;
  logic [ADDR_W-1:0] vz_addr_q;
  logic [7:0]        vz_data_q;
  logic              load_done_q;
  logic              load_err_q;
  logic [ADDR_W-1:0] exec_addr_q;

  logic              dl_rise;
  logic              dl_fall;
  logic              fifo_full;
  logic              push;
  logic              pop;
  logic              err_now;
  logic [ENT_W-1:0]  fifo_head;
  logic [ENT_W-1:0]  fifo_next;
  logic [ADDR_W-1:0] patch_addr;
  logic [7:0]        patch_data;
  logic [2:0]        patch_last;
  logic [7:0]        end_lo;
  logic [7:0]        end_hi;

  assign dl_rise   = bus.ioctl_download & ~dl_q;
  assign dl_fall   = ~bus.ioctl_download & dl_q;
  assign fifo_full = (count == CNT_FULL);

  // A byte that arrives while full or after the address wrapped is not
  // pushed; it is turned into an error instead.
  assign push = (state == S_BODY) && bus.ioctl_wr && !fifo_full && !wrapped;
  assign pop  = ((state == S_BODY) || (state == S_DRAIN)) && vz_wr_q && bus.vz_ack;

  assign fifo_head = fifo_mem[rd_ptr];
  assign fifo_next = fifo_mem[rd_ptr + PTR_W'(1)];

  assign end_lo     = cur_addr[7:0];
  assign end_hi     = 8'(cur_addr >> 8);
  assign patch_last = is_basic_q ? 3'd7 : 3'd1;

  assign bus.ioctl_wait = fifo_full;
  assign bus.vz_wr      = vz_wr_q;
  assign bus.vz_addr    = vz_addr_q;
  assign bus.vz_data    = vz_data_q;

  assign load_done = load_done_q;
  assign load_err  = load_err_q;
  assign exec_addr = exec_addr_q;
  assign is_basic  = is_basic_q;

  // Conditions that abort the current load: bad magic or type byte, a file
  // that ends inside the header, a FIFO overrun, or a byte past the address
  // wrap.
  always_comb begin
    err_now = 1'b0;
    case (state)
      S_HEADER: begin
        if (dl_fall) err_now = 1'b1;
        if (bus.ioctl_wr) begin
          if (bus.ioctl_addr == OFS_MAGIC0 && bus.ioctl_data != 8'h56) err_now = 1'b1;
          if (bus.ioctl_addr == OFS_MAGIC1 && bus.ioctl_data != 8'h5A) err_now = 1'b1;
          if (bus.ioctl_addr == OFS_TYPE &&
              bus.ioctl_data != 8'hF0 && bus.ioctl_data != 8'hF1) err_now = 1'b1;
        end
      end
      S_BODY: begin
        if (bus.ioctl_wr && (fifo_full || wrapped)) err_now = 1'b1;
      end
      default: ;
    endcase
  end

  // Pointer patch table, high byte of each pair written first. The end
  // pointers take cur_addr, which by then is one past the last body byte.
  always_comb begin
    patch_addr = '0;
    patch_data = '0;
    if (is_basic_q) begin
      case (patch_idx)
        3'd0: begin patch_addr = BASIC_PTR + ONE_A;          patch_data = start_hi; end
        3'd1: begin patch_addr = BASIC_PTR;                  patch_data = start_lo; end
        3'd2: begin patch_addr = BASIC_END + ONE_A;          patch_data = end_hi;   end
        3'd3: begin patch_addr = BASIC_END;                  patch_data = end_lo;   end
        3'd4: begin patch_addr = BASIC_END + ADDR_W'(3);     patch_data = end_hi;   end
        3'd5: begin patch_addr = BASIC_END + ADDR_W'(2);     patch_data = end_lo;   end
        3'd6: begin patch_addr = BASIC_END + ADDR_W'(5);     patch_data = end_hi;   end
        default: begin patch_addr = BASIC_END + ADDR_W'(4);  patch_data = end_lo;   end
      endcase
    end else begin
      if (patch_idx == 3'd0) begin
        patch_addr = MCODE_PTR + ONE_A;
        patch_data = start_hi;
      end else begin
        patch_addr = MCODE_PTR;
        patch_data = start_lo;
      end
    end
  end

  // Main controller: header parsing, FIFO, RAM write port and patching.
  // A new download always wins, then an error, then normal sequencing.
  always_ff @(posedge I_CLK or negedge I_RST_N) begin
    if (!I_RST_N) begin
      state       <= S_IDLE;
      dl_q        <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_mem[i] <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      cur_addr    <= '0;
      start_lo    <= '0;
      start_hi    <= '0;
      is_basic_q  <= 1'b0;
      wrapped     <= 1'b0;
      patch_idx   <= '0;
      vz_wr_q     <= 1'b0;
      vz_addr_q   <= '0;
      vz_data_q   <= '0;
      load_done_q <= 1'b0;
      load_err_q  <= 1'b0;
      exec_addr_q <= '0;
    end else begin
      dl_q        <= bus.ioctl_download;
      load_done_q <= 1'b0;

      if (dl_rise) begin
        state      <= S_HEADER;
        load_err_q <= 1'b0;
        vz_wr_q    <= 1'b0;
        wr_ptr     <= '0;
        rd_ptr     <= '0;
        count      <= '0;
        wrapped    <= 1'b0;
        patch_idx  <= '0;
      end else if (err_now) begin
        state      <= S_ERROR;
        load_err_q <= 1'b1;
        vz_wr_q    <= 1'b0;
        wr_ptr     <= '0;
        rd_ptr     <= '0;
        count      <= '0;
      end else begin
        case (state)
          S_HEADER: begin
            if (bus.ioctl_wr) begin
              if (bus.ioctl_addr == OFS_TYPE) is_basic_q <= (bus.ioctl_data == 8'hF0);
              if (bus.ioctl_addr == OFS_LO) start_lo <= bus.ioctl_data;
              if (bus.ioctl_addr == OFS_HI) begin
                start_hi <= bus.ioctl_data;
                cur_addr <= ADDR_W'({bus.ioctl_data, start_lo});
                wrapped  <= 1'b0;
                state    <= S_BODY;
              end
            end
          end

          S_BODY, S_DRAIN: begin
            if (push) begin
              fifo_mem[wr_ptr] <= {cur_addr, bus.ioctl_data};
              wr_ptr   <= wr_ptr + PTR_W'(1);
              cur_addr <= cur_addr + ONE_A;
              if (cur_addr == '1) wrapped <= 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(push) - CNT_W'(pop);

            // The head entry is copied to the write port but only leaves
            // the FIFO on ack, so ioctl_wait reflects every queued byte.
            // On ack, a second queued entry is presented back-to-back.
            if (!vz_wr_q) begin
              if (count != '0) begin
                vz_wr_q   <= 1'b1;
                vz_addr_q <= fifo_head[ENT_W-1:8];
                vz_data_q <= fifo_head[7:0];
              end
            end else if (bus.vz_ack) begin
              if (count > CNT_ONE) begin
                vz_addr_q <= fifo_next[ENT_W-1:8];
                vz_data_q <= fifo_next[7:0];
              end else begin
                vz_wr_q <= 1'b0;
              end
            end

            if (state == S_BODY && dl_fall) state <= S_DRAIN;
            if (state == S_DRAIN && count == '0 && !vz_wr_q) begin
              state     <= S_PATCH;
              patch_idx <= '0;
            end
          end

          S_PATCH: begin
            if (!vz_wr_q) begin
              vz_wr_q   <= 1'b1;
              vz_addr_q <= patch_addr;
              vz_data_q <= patch_data;
            end else if (bus.vz_ack) begin
              vz_wr_q <= 1'b0;
              if (patch_idx == patch_last) begin
                state       <= S_DONE;
                load_done_q <= 1'b1;
                exec_addr_q <= ADDR_W'({start_hi, start_lo});
              end else begin
                patch_idx <= patch_idx + 3'd1;
              end
            end
          end

          S_DONE: state <= S_IDLE;

          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_vz_image_loader.sv
// tb_vz_image_loader
//   Self-checking bench for vz_image_loader. Files are built as byte
//   queues, streamed over the ioctl port, and the acknowledged RAM writes
//   are compared with a reference model that derives the expected write
//   list directly from the .VZ file layout.
module tb_vz_image_loader;

  localparam int ADDR_W     = 16;
  localparam int FIFO_DEPTH = 4;

  logic              I_CLK   = 1'b0;
  logic              I_RST_N = 1'b0;
  logic              load_done;
  logic              load_err;
  logic              is_basic;
  logic [ADDR_W-1:0] exec_addr;

  vz_image_loader_if #(.ADDR_W(ADDR_W)) bus ();

  vz_image_loader #(
    .ADDR_W    (ADDR_W),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .I_CLK    (I_CLK),
    .I_RST_N  (I_RST_N),
    .bus      (bus),
    .load_done(load_done),
    .load_err (load_err),
    .exec_addr(exec_addr),
    .is_basic (is_basic)
  );

  always #5 I_CLK = ~I_CLK;

  typedef struct {
    logic [7:0]  b0;
    logic [7:0]  b1;
    logic [7:0]  typ;
    logic [15:0] start;
    int          body_len;
    int          cut;
    int          ack_m;
    bit          exp_err;
    int          exp_wr;
  } vec_t;

  int          total = 0;
  int          bad   = 0;
  int          ack_mode = 0;
  logic [7:0]  cur_f[$];
  logic [23:0] exp_q[$];
  logic [23:0] got_q[$];
  int          wr_seen = 0;
  int          done_cnt = 0;
  int          stall_viol = 0;
  logic [15:0] done_exec = '0;
  logic        done_basic = 1'b0;
  bit          prev_stall = 1'b0;
  logic [15:0] prev_addr = '0;
  logic [7:0]  prev_data = '0;
  bit          m_err;
  bit          m_basic;
  logic [15:0] m_start;

  // RAM responder: ack pattern chosen per test.
  always @(posedge I_CLK) begin
    #1;
    case (ack_mode)
      0:       bus.vz_ack = 1'b1;
      1:       bus.vz_ack = 1'($urandom_range(0, 1));
      default: bus.vz_ack = 1'b0;
    endcase
  end

  // Monitor on the falling edge: records accepted writes, done pulses and
  // any change of a pending write while the RAM is stalling.
  always @(negedge I_CLK) begin
    if (I_RST_N) begin
      if (prev_stall && (!bus.vz_wr || bus.vz_addr != prev_addr || bus.vz_data != prev_data))
        stall_viol++;
      prev_stall = bus.vz_wr && !bus.vz_ack;
      prev_addr  = bus.vz_addr;
      prev_data  = bus.vz_data;
      if (bus.vz_wr) wr_seen++;
      if (bus.vz_wr && bus.vz_ack) got_q.push_back({bus.vz_addr, bus.vz_data});
      if (load_done) begin
        done_cnt++;
        done_exec  = exec_addr;
        done_basic = is_basic;
      end
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic tick();
    @(posedge I_CLK);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, want %0h", name, actual, expected);
    end
  endtask

  task automatic buildFile(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] typ,
                           input logic [15:0] start, input int len, input int cut);
    cur_f.delete();
    cur_f.push_back(b0);
    cur_f.push_back(b1);
    for (int i = 2; i < 21; i++) cur_f.push_back(8'($urandom));
    cur_f.push_back(typ);
    cur_f.push_back(start[7:0]);
    cur_f.push_back(start[15:8]);
    for (int i = 0; i < len; i++) cur_f.push_back(8'($urandom));
    if (cut > 0) while (cur_f.size() > cut) void'(cur_f.pop_back());
  endtask

  // Reference model: what RAM should see for the file in cur_f.
  function automatic void modelFile();
    int body;
    int endp;
    exp_q.delete();
    m_err   = 1'b0;
    m_basic = 1'b0;
    m_start = '0;
    if (cur_f.size() < 24) begin m_err = 1'b1; return; end
    if (cur_f[0] != 8'h56 || cur_f[1] != 8'h5A) begin m_err = 1'b1; return; end
    if (cur_f[21] != 8'hF0 && cur_f[21] != 8'hF1) begin m_err = 1'b1; return; end
    m_basic = (cur_f[21] == 8'hF0);
    m_start = {cur_f[23], cur_f[22]};
    body    = cur_f.size() - 24;
    if (int'(m_start) + body > 65536) begin m_err = 1'b1; return; end
    for (int i = 0; i < body; i++) exp_q.push_back({16'(int'(m_start) + i), cur_f[24 + i]});
    endp = (int'(m_start) + body) % 65536;
    if (m_basic) begin
      exp_q.push_back({16'h78A5, m_start[15:8]});
      exp_q.push_back({16'h78A4, m_start[7:0]});
      for (int k = 0; k < 6; k += 2) begin
        exp_q.push_back({16'(16'h78F9 + k + 1), 8'(endp >> 8)});
        exp_q.push_back({16'(16'h78F9 + k), 8'(endp)});
      end
    end else begin
      exp_q.push_back({16'h788F, m_start[15:8]});
      exp_q.push_back({16'h788E, m_start[7:0]});
    end
  endfunction

  task automatic sendByte(input logic [15:0] addr, input logic [7:0] data);
    int guard = 0;
    while (bus.ioctl_wait && guard < 300) begin
      tick();
      guard++;
    end
    if (guard >= 300) checkOutput("wait_release", bus.ioctl_wait, 0);
    bus.ioctl_wr   = 1'b1;
    bus.ioctl_addr = addr;
    bus.ioctl_data = data;
    tick();
    bus.ioctl_wr = 1'b0;
    repeat ($urandom_range(0, 1)) tick();
  endtask

  task automatic startLoad(input int ack_m);
    got_q.delete();
    wr_seen  = 0;
    done_cnt = 0;
    ack_mode = ack_m;
    bus.ioctl_download = 1'b1;
    tick();
    tick();
  endtask

  task automatic waitEnd();
    int n = 0;
    while (done_cnt == 0 && !load_err && n < 500) begin
      tick();
      n++;
    end
    checkOutput("load_finished", (done_cnt != 0) || load_err, 1);
    repeat (4) tick();
  endtask

  task automatic applyStimulus(input int ack_m);
    startLoad(ack_m);
    checkOutput("err_clear_on_start", load_err, 0);
    for (int i = 0; i < cur_f.size(); i++) sendByte(16'(i), cur_f[i]);
    tick();
    bus.ioctl_download = 1'b0;
    waitEnd();
  endtask

  task automatic checkResult(input string tag, input bit exp_err, input int exp_wr);
    int n;
    checkOutput({tag, "_err"}, load_err, exp_err);
    checkOutput({tag, "_done_cnt"}, done_cnt, exp_err ? 0 : 1);
    if (exp_wr >= 0) checkOutput({tag, "_nwr"}, got_q.size(), exp_wr);
    if (exp_err && exp_wr == 0) checkOutput({tag, "_vzwr_seen"}, wr_seen, 0);
    if (!exp_err) begin
      checkOutput({tag, "_exec"}, done_exec, m_start);
      checkOutput({tag, "_basic"}, done_basic, m_basic);
      checkOutput({tag, "_nwr_model"}, got_q.size(), exp_q.size());
      n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
      for (int i = 0; i < n; i++)
        checkOutput($sformatf("%s_wr%0d", tag, i), got_q[i], exp_q[i]);
    end
  endtask

  vec_t vecs[10];

  initial begin
    vecs[0] = '{8'h56, 8'h5A, 8'hF1, 16'h8000, 3, 0,  0, 1'b0, 5};
    vecs[1] = '{8'h56, 8'h5A, 8'hF0, 16'h7AE9, 2, 0,  0, 1'b0, 10};
    vecs[2] = '{8'h41, 8'h5A, 8'hF1, 16'h8000, 2, 0,  0, 1'b1, 0};
    vecs[3] = '{8'h56, 8'h5A, 8'h33, 16'h8000, 2, 0,  1, 1'b1, 0};
    vecs[4] = '{8'h56, 8'h5A, 8'hF1, 16'h8000, 2, 10, 0, 1'b1, 0};
    vecs[5] = '{8'h56, 8'h5A, 8'hF1, 16'h9000, 4, 0,  1, 1'b0, 6};
    vecs[6] = '{8'h56, 8'h41, 8'hF0, 16'h8000, 1, 0,  0, 1'b1, 0};
    vecs[7] = '{8'h56, 8'h5A, 8'hF0, 16'hFFFE, 2, 0,  1, 1'b0, 10};
    vecs[8] = '{8'h56, 8'h5A, 8'hF1, 16'hFFFE, 3, 0,  0, 1'b1, -1};
    vecs[9] = '{8'h56, 8'h5A, 8'hF1, 16'h1234, 0, 0,  0, 1'b0, 2};

    bus.ioctl_download = 1'b0;
    bus.ioctl_wr       = 1'b0;
    bus.ioctl_addr     = '0;
    bus.ioctl_data     = '0;

    // Reset state.
    I_RST_N = 1'b0;
    repeat (3) tick();
    checkOutput("rst_vz_wr", bus.vz_wr, 0);
    checkOutput("rst_wait", bus.ioctl_wait, 0);
    checkOutput("rst_done", load_done, 0);
    checkOutput("rst_err", load_err, 0);
    checkOutput("rst_exec", exec_addr, 0);
    checkOutput("rst_basic", is_basic, 0);
    I_RST_N = 1'b1;
    tick();

    // Table of files with hand-derived outcomes.
    for (int v = 0; v < 10; v++) begin
      buildFile(vecs[v].b0, vecs[v].b1, vecs[v].typ, vecs[v].start, vecs[v].body_len, vecs[v].cut);
      modelFile();
      applyStimulus(vecs[v].ack_m);
      checkResult($sformatf("vec%0d", v), vecs[v].exp_err, vecs[v].exp_wr);
      if (v == 0) begin
        checkOutput("v0_body0", got_q[0], {16'h8000, cur_f[24]});
        checkOutput("v0_patch_hi", got_q[3], 24'h788F80);
        checkOutput("v0_patch_lo", got_q[4], 24'h788E00);
        checkOutput("v0_exec", done_exec, 16'h8000);
      end
      if (v == 1) begin
        checkOutput("v1_basic_hi", got_q[2], 24'h78A57A);
        checkOutput("v1_basic_lo", got_q[3], 24'h78A4E9);
        checkOutput("v1_end0_hi", got_q[4], 24'h78FA7A);
        checkOutput("v1_end0_lo", got_q[5], 24'h78F9EB);
        checkOutput("v1_end2_lo", got_q[9], 24'h78FDEB);
      end
      if (v == 7) checkOutput("v7_end_wrap", got_q[5], 24'h78F900);
    end

    // RAM stalled 20 cycles with 6 body bytes: FIFO fills at 4.
    buildFile(8'h56, 8'h5A, 8'hF1, 16'h4000, 6, 0);
    modelFile();
    startLoad(2);
    for (int i = 0; i < 28; i++) sendByte(16'(i), cur_f[i]);
    tick();
    checkOutput("stall_wait_full", bus.ioctl_wait, 1);
    stall_viol = 0;
    repeat (20) tick();
    checkOutput("stall_stable", stall_viol, 0);
    checkOutput("stall_vz_wr", bus.vz_wr, 1);
    checkOutput("stall_addr", bus.vz_addr, 16'h4000);
    checkOutput("stall_data", bus.vz_data, cur_f[24]);
    ack_mode = 0;
    for (int i = 28; i < 30; i++) sendByte(16'(i), cur_f[i]);
    tick();
    bus.ioctl_download = 1'b0;
    waitEnd();
    checkResult("stall", 1'b0, 8);

    // Overrun: strobe forced while the FIFO is full.
    buildFile(8'h56, 8'h5A, 8'hF1, 16'h5000, 8, 0);
    startLoad(2);
    for (int i = 0; i < 28; i++) sendByte(16'(i), cur_f[i]);
    tick();
    bus.ioctl_wr   = 1'b1;
    bus.ioctl_addr = 16'd28;
    bus.ioctl_data = cur_f[28];
    tick();
    bus.ioctl_wr = 1'b0;
    tick();
    checkOutput("ovr_err", load_err, 1);
    checkOutput("ovr_vz_wr", bus.vz_wr, 0);
    checkOutput("ovr_flushed", bus.ioctl_wait, 0);
    ack_mode = 0;
    bus.ioctl_download = 1'b0;
    repeat (10) tick();
    checkOutput("ovr_nwr", got_q.size(), 0);
    checkOutput("ovr_done", done_cnt, 0);

    // Asynchronous reset in BODY with two entries pending.
    buildFile(8'h56, 8'h5A, 8'hF0, 16'h6000, 4, 0);
    startLoad(2);
    for (int i = 0; i < 26; i++) sendByte(16'(i), cur_f[i]);
    tick();
    tick();
    checkOutput("arst_pending", bus.vz_wr, 1);
    #2;
    I_RST_N = 1'b0;
    #1;
    checkOutput("arst_vz_wr", bus.vz_wr, 0);
    checkOutput("arst_wait", bus.ioctl_wait, 0);
    checkOutput("arst_err", load_err, 0);
    bus.ioctl_download = 1'b0;
    ack_mode = 0;
    tick();
    tick();
    I_RST_N = 1'b1;
    got_q.delete();
    done_cnt = 0;
    repeat (30) tick();
    checkOutput("arst_no_wr", got_q.size(), 0);
    checkOutput("arst_no_done", done_cnt, 0);

    // Randomized files against the reference model.
    for (int r = 0; r < 10; r++) begin
      logic [7:0] typ;
      if ($urandom_range(0, 4) == 0) typ = 8'($urandom);
      else typ = $urandom_range(0, 1) ? 8'hF0 : 8'hF1;
      buildFile(8'h56, 8'h5A, typ, 16'($urandom), $urandom_range(0, 10), 0);
      modelFile();
      applyStimulus($urandom_range(0, 1));
      checkResult($sformatf("rnd%0d", r), m_err, m_err ? -1 : exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout, want completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
